// File: rtl/gba_bus_pkg.sv
// Shared types and sizes for the GBA cartridge ROM bus controller.
package gba_bus_pkg;
  localparam int GBA_ADDR_W      = 24;
  localparam int GBA_DATA_W      = 16;
  localparam int GBA_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_READY,
    ST_DRIVE
  } state_e;
endpackage

// File: rtl/gba_sync.sv
// N-stage strobe synchronizer (FFs reset high) with registered edge pulses.
// lvl_o is the delayed synchronized level, aligned with rise_o/fall_o.
module gba_sync #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [N-1:0] sync_q;
  logic         prev_q, rise_q, fall_q;

  // Shift raw strobe in, compare synchronized value with its delayed copy.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
      prev_q <= sync_q[N-1];
      rise_q <= sync_q[N-1] & ~prev_q;
      fall_q <= ~sync_q[N-1] & prev_q;
    end
  end

  assign lvl_o  = prev_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/gba_rom_bus_ctrl.sv
// GBA cartridge ROM bus sequencer: strobe sync, address latch, fetch and
// prefetch from backing store, AD pad output-enable control.
// Optional feature macro: GBA_BUS_LATE_CNT_EN (saturating late-read counter).
module gba_rom_bus_ctrl
  import gba_bus_pkg::*;
#(
  parameter int SYNC_STAGES = GBA_SYNC_STAGES,
  parameter int ADDR_W      = GBA_ADDR_W
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  gba_ncs,
  input  logic                  gba_nrd,
  input  logic                  gba_nwr,
  input  logic [GBA_DATA_W-1:0] gba_ad_in,
  input  logic [7:0]            gba_a_in,
  output logic [GBA_DATA_W-1:0] gba_ad_out,
  output logic                  gba_ad_oe,
  output logic [7:0]            gba_a_out,
  output logic                  gba_a_oe,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [GBA_DATA_W-1:0] mem_rsp_data,
  output logic [15:0]           late_cnt
);
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic nrd_lvl, nrd_rise, nrd_fall;
  logic nwr_lvl, nwr_rise, nwr_fall;

  gba_sync #(.N(SYNC_STAGES)) u_sync_ncs (.clk_i(sys_clk), .rst_n_i(sys_rst_n), .d_i(gba_ncs),
    .lvl_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall));
  gba_sync #(.N(SYNC_STAGES)) u_sync_nrd (.clk_i(sys_clk), .rst_n_i(sys_rst_n), .d_i(gba_nrd),
    .lvl_o(nrd_lvl), .rise_o(nrd_rise), .fall_o(nrd_fall));
  gba_sync #(.N(SYNC_STAGES)) u_sync_nwr (.clk_i(sys_clk), .rst_n_i(sys_rst_n), .d_i(gba_nwr),
    .lvl_o(nwr_lvl), .rise_o(nwr_rise), .fall_o(nwr_fall));

  // Writes are not decoded on ROM cycles; only the nwr level gates oe.
  logic unused_strobes;
  assign unused_strobes = &{1'b0, ncs_lvl, nrd_lvl, nwr_rise, nwr_fall};

  state_e                state_q;
  logic [ADDR_W-1:0]     addr_q, req_addr_q;
  logic [GBA_DATA_W-1:0] data_q, ad_out_q;
  logic                  drop_q, busy_q, pend_q, req_valid_q, ad_oe_q;

  // busy_q: request accepted, response pending. pend_q: addr_q still needs
  // a request. A request is only issued when nothing is in flight.
  logic issue, outstanding, stale_on_exit;
  assign issue         = pend_q && !req_valid_q && !busy_q && !drop_q;
  assign outstanding   = (busy_q && !mem_rsp_valid) || (req_valid_q && mem_req_ready);
  assign stale_on_exit = (busy_q && !mem_rsp_valid) || req_valid_q || issue;

  // Main sequencer: request handshake bookkeeping, then state transitions;
  // ncs rise overrides everything and aborts the ROM cycle.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      req_addr_q  <= '0;
      data_q      <= '0;
      ad_out_q    <= '0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      req_valid_q <= 1'b0;
      ad_oe_q     <= 1'b0;
    end else begin
      ad_oe_q <= 1'b0;
      if (mem_rsp_valid && busy_q) begin
        busy_q <= 1'b0;
        drop_q <= 1'b0;
        if (!drop_q) data_q <= mem_rsp_data;
      end
      if (req_valid_q && mem_req_ready) begin
        req_valid_q <= 1'b0;
        busy_q      <= 1'b1;
      end else if (issue) begin
        req_valid_q <= 1'b1;
        req_addr_q  <= addr_q;
        pend_q      <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: if (ncs_fall) begin
          addr_q  <= ADDR_W'({gba_a_in, gba_ad_in});
          pend_q  <= 1'b1;
          state_q <= ST_FETCH;
        end
        ST_FETCH, ST_WAIT: if (nrd_fall) begin
          // Late read: drive whatever data_q holds; the response refreshes it.
          state_q  <= ST_DRIVE;
          ad_oe_q  <= nwr_lvl;
          ad_out_q <= data_q;
        end else if (state_q == ST_FETCH && req_valid_q && mem_req_ready) begin
          state_q <= ST_WAIT;
        end else if (state_q == ST_WAIT && mem_rsp_valid && busy_q && !drop_q) begin
          state_q <= ST_READY;
        end
        ST_READY: if (nrd_fall) begin
          state_q  <= ST_DRIVE;
          ad_oe_q  <= nwr_lvl;
          ad_out_q <= data_q;
        end
        ST_DRIVE: if (nrd_rise) begin
          addr_q  <= addr_q + 1'b1;
          pend_q  <= 1'b1;
          drop_q  <= stale_on_exit;
          state_q <= ST_FETCH;
        end else begin
          ad_oe_q  <= nwr_lvl;
          ad_out_q <= data_q;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (ncs_rise) begin
        state_q     <= ST_IDLE;
        ad_oe_q     <= 1'b0;
        req_valid_q <= 1'b0;
        pend_q      <= 1'b0;
        drop_q      <= outstanding;
      end
    end
  end

`ifdef GBA_BUS_LATE_CNT_EN
  logic [15:0] late_q;
  logic        late_evt;
  assign late_evt = nrd_fall && !ncs_rise && (state_q == ST_FETCH || state_q == ST_WAIT);

  // Saturating count of reads that started before their data arrived.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)                       late_q <= '0;
    else if (late_evt && late_q != 16'hFFFF) late_q <= late_q + 16'd1;
  end
  assign late_cnt = late_q;
`else
  assign late_cnt = '0;
`endif

  assign gba_ad_out    = ad_out_q;
  assign gba_ad_oe     = ad_oe_q;
  assign gba_a_out     = '0;
  assign gba_a_oe      = 1'b0;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
endmodule

// File: tb/tb_gba_rom_bus_ctrl.sv
// Scoreboard bench for gba_rom_bus_ctrl: stimulus pushes expected request
// addresses and driven halfwords; a monitor pops and compares them.
module tb_gba_rom_bus_ctrl;
  logic        sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic        gba_ncs = 1'b1, gba_nrd = 1'b1, gba_nwr = 1'b1;
  logic [15:0] gba_ad_in = '0;
  logic [7:0]  gba_a_in = '0;
  logic [15:0] gba_ad_out;
  logic        gba_ad_oe;
  logic [7:0]  gba_a_out;
  logic        gba_a_oe;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [23:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [15:0] mem_rsp_data = '0;
  logic [15:0] late_cnt;

  int total = 0, bad = 0;
  int lat = 5;
  logic        oe_prev = 1'b0;
  logic [23:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];

`ifdef GBA_BUS_LATE_CNT_EN
  localparam logic [15:0] EXP_LATE = 16'd1;
`else
  localparam logic [15:0] EXP_LATE = 16'd0;
`endif

  gba_rom_bus_ctrl dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .gba_ncs(gba_ncs), .gba_nrd(gba_nrd), .gba_nwr(gba_nwr),
    .gba_ad_in(gba_ad_in), .gba_a_in(gba_a_in),
    .gba_ad_out(gba_ad_out), .gba_ad_oe(gba_ad_oe),
    .gba_a_out(gba_a_out), .gba_a_oe(gba_a_oe),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .late_cnt(late_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [15:0] fdata(input logic [23:0] a);
    case (a)
      24'h123456: fdata = 16'hBEEF;
      24'hFFFFFE: fdata = 16'h1111;
      24'hFFFFFF: fdata = 16'h2222;
      24'h000000: fdata = 16'h3333;
      24'h000001: fdata = 16'h4444;
      24'h000100: fdata = 16'hC0DE;
      default:    fdata = a[15:0];
    endcase
  endfunction

  // Backing-store model: one request at a time, fixed latency after accept.
  initial begin
    logic [23:0] a;
    forever begin
      @(negedge sys_clk);
      if (mem_req_valid && mem_req_ready && sys_rst_n) begin
        a = mem_req_addr;
        @(posedge sys_clk);
        repeat (lat) @(posedge sys_clk);
        #1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = fdata(a);
        @(posedge sys_clk);
        #1;
        mem_rsp_valid = 1'b0;
      end
    end
  end

  // Monitor: accepted requests and oe rising edges are checked against queues.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (mem_req_valid && mem_req_ready) begin
        if (exp_addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL req_addr: got unexpected request %0h, none expected", mem_req_addr);
        end else chk("req_addr", {8'h0, mem_req_addr}, {8'h0, exp_addr_q.pop_front()});
      end
      if (gba_ad_oe && !oe_prev) begin
        if (exp_data_q.size() == 0) begin
          total++; bad++;
          $display("FAIL drive_data: got unexpected drive %0h, none expected", gba_ad_out);
        end else chk("drive_data", {16'h0, gba_ad_out}, {16'h0, exp_data_q.pop_front()});
      end
      oe_prev = gba_ad_oe;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ad_out"}, {16'h0, gba_ad_out}, 32'h0);
    chk({tag, "_ad_oe"}, {31'h0, gba_ad_oe}, 32'h0);
    chk({tag, "_a_out"}, {24'h0, gba_a_out}, 32'h0);
    chk({tag, "_a_oe"}, {31'h0, gba_a_oe}, 32'h0);
    chk({tag, "_req_valid"}, {31'h0, mem_req_valid}, 32'h0);
    chk({tag, "_req_addr"}, {8'h0, mem_req_addr}, 32'h0);
    chk({tag, "_late"}, {16'h0, late_cnt}, 32'h0);
  endtask

  task automatic start_cycle(input logic [23:0] a);
    gba_a_in  = a[23:16];
    gba_ad_in = a[15:0];
    gba_ncs   = 1'b0;
  endtask

  initial begin
    cyc(3);
    chk_reset_vals("rst");
    sys_rst_n = 1'b1;
    cyc(2);

    // Single read at 0x123456, 5-cycle memory, latency of oe on and off.
    lat = 5;
    exp_addr_q.push_back(24'h123456);
    start_cycle(24'h123456);
    cyc(15);
    exp_data_q.push_back(16'hBEEF);
    gba_nrd = 1'b0;
    cyc(3);
    chk("oe_on_early", {31'h0, gba_ad_oe}, 32'h0);
    cyc(1);
    chk("oe_on_lat", {31'h0, gba_ad_oe}, 32'h1);
    chk("ad_beef", {16'h0, gba_ad_out}, 32'hBEEF);
    cyc(4);
    exp_addr_q.push_back(24'h123457);
    gba_nrd = 1'b1;
    cyc(3);
    chk("oe_off_early", {31'h0, gba_ad_oe}, 32'h1);
    cyc(1);
    chk("oe_off_lat", {31'h0, gba_ad_oe}, 32'h0);
    cyc(15);
    gba_ncs = 1'b1;
    cyc(8);

    // Burst across the address wrap, 2-cycle memory.
    lat = 2;
    exp_addr_q.push_back(24'hFFFFFE);
    start_cycle(24'hFFFFFE);
    cyc(15);
    begin
      logic [15:0] bd [4];
      logic [23:0] ba [4];
      bd[0] = 16'h1111; bd[1] = 16'h2222; bd[2] = 16'h3333; bd[3] = 16'h4444;
      ba[0] = 24'hFFFFFF; ba[1] = 24'h000000; ba[2] = 24'h000001; ba[3] = 24'h000002;
      for (int i = 0; i < 4; i++) begin
        exp_data_q.push_back(bd[i]);
        exp_addr_q.push_back(ba[i]);
        gba_nrd = 1'b0;
        cyc(8);
        gba_nrd = 1'b1;
        cyc(12);
      end
    end
    chk("burst_late", {16'h0, late_cnt}, 32'h0);
    gba_ncs = 1'b1;
    cyc(8);

    // Late read: stale halfword (0x0002 from burst prefetch) then real data.
    lat = 20;
    exp_addr_q.push_back(24'h000200);
    start_cycle(24'h000200);
    cyc(8);
    exp_data_q.push_back(16'h0002);
    gba_nrd = 1'b0;
    cyc(30);
    chk("late_update", {16'h0, gba_ad_out}, 32'h0200);
    chk("late_oe", {31'h0, gba_ad_oe}, 32'h1);
    chk("late_cnt", {16'h0, late_cnt}, {16'h0, EXP_LATE});
    lat = 2;
    exp_addr_q.push_back(24'h000201);
    gba_nrd = 1'b1;
    cyc(12);
    gba_ncs = 1'b1;
    cyc(8);

    // Abort with a request outstanding; stale response must be discarded.
    lat = 20;
    exp_addr_q.push_back(24'h000300);
    start_cycle(24'h000300);
    cyc(10);
    gba_ncs = 1'b1;
    cyc(5);
    lat = 3;
    exp_addr_q.push_back(24'h000100);
    start_cycle(24'h000100);
    cyc(8);
    chk("drop_hold", {31'h0, mem_req_valid}, 32'h0);
    cyc(20);
    exp_data_q.push_back(16'hC0DE);
    exp_addr_q.push_back(24'h000101);
    gba_nrd = 1'b0;
    cyc(8);
    gba_nrd = 1'b1;
    cyc(12);

    // nwr alone is ignored; nrd with nwr low keeps oe off.
    gba_nwr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("nwr_oe", {31'h0, gba_ad_oe}, 32'h0);
      chk("nwr_req", {31'h0, mem_req_valid}, 32'h0);
    end
    gba_nwr = 1'b1;
    cyc(6);
    exp_addr_q.push_back(24'h000102);
    gba_nwr = 1'b0;
    gba_nrd = 1'b0;
    cyc(8);
    chk("rdwr_oe", {31'h0, gba_ad_oe}, 32'h0);
    gba_nwr = 1'b1;
    gba_nrd = 1'b1;
    cyc(12);

    // Reset mid-DRIVE.
    exp_data_q.push_back(16'h0102);
    gba_nrd = 1'b0;
    cyc(6);
    chk("pre_rst_oe", {31'h0, gba_ad_oe}, 32'h1);
    chk("pre_rst_late", {16'h0, late_cnt}, {16'h0, EXP_LATE});
    sys_rst_n = 1'b0;
    gba_ncs   = 1'b1;
    gba_nrd   = 1'b1;
    cyc(1);
    chk_reset_vals("midrst");
    sys_rst_n = 1'b1;
    cyc(10);
    chk("idle_req", {31'h0, mem_req_valid}, 32'h0);
    chk("idle_oe", {31'h0, gba_ad_oe}, 32'h0);

    chk("addr_q_empty", exp_addr_q.size(), 32'h0);
    chk("data_q_empty", exp_data_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
